am2901_ctrl_pipe: RTL

Parametrised, pipelined successor to the combinational Am2901 slice controller. It drives an N-slice (4*SLICES-bit) Am2901-style datapath from a registered micro-instruction stage. It adds a valid/ready instruction handshake, a repeat counter for multi-cycle shift loops (multiply/divide steps), and a registered status-flag file. It sits between the microsequencer and the cascaded register-file/ALU/shifter slices.

---
 rtl/am2901_ctrl_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/am2901_ctrl_pipe.sv
// Pipelined Am2901 slice controller: registered micro-instruction stage with
// valid/ready handshake, repeat counter for shift loops and registered status flags.
module am2901_ctrl_pipe #(
  parameter int unsigned SLICES = 4,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned CNT_W  = 4,
  localparam int unsigned W     = 4 * SLICES,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [8:0]       i,
  input  logic [AW-1:0]    a,
  input  logic [AW-1:0]    b,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [W-1:0]     f,
  input  logic             cout_msb,
  input  logic             cin_msb,
  output logic [NREGS-1:0] select_a_hi,
  output logic [NREGS-1:0] select_b_hi,
  output logic [2:0]       src_sel,
  output logic [2:0]       fn_sel,
  output logic [2:0]       dst_sel,
  output logic             reg_wr,
  output logic             q_wr,
  output logic             y_sel_a,
  output logic             shift_left,
  output logic             shift_right,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_ovr
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [8:0]       ir;
  logic [AW-1:0]    ir_a, ir_b;
  logic             run_en;
  logic             accept;
  logic             last;
  logic [2:0]       d;

  assign last    = (cnt == '0);
  assign d       = ir[8:6];
  assign src_sel = ir[2:0];
  assign fn_sel  = ir[5:3];
  assign dst_sel = ir[8:6];

  // State and repeat counter; run_en keeps ready low while reset is asserted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      run_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      run_en <= 1'b1;
    end
  end

  // Instruction register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir   <= '0;
      ir_a <= '0;
      ir_b <= '0;
    end else if (accept) begin
      ir   <= i;
      ir_a <= a;
      ir_b <= b;
    end
  end

  // Status flags capture the datapath result at the end of every execution cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_c   <= 1'b0;
      flag_ovr <= 1'b0;
    end else if (state == EXEC) begin
      flag_z   <= (f == '0);
      flag_n   <= f[W-1];
      flag_c   <= cout_msb;
      flag_ovr <= cout_msb ^ cin_msb;
    end
  end

  // Next state, handshake and decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    instr_ready = 1'b0;
    busy        = 1'b0;
    select_a_hi = '0;
    select_b_hi = '0;
    reg_wr      = 1'b0;
    q_wr        = 1'b0;
    y_sel_a     = 1'b0;
    shift_left  = 1'b0;
    shift_right = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = run_en;
        accept      = instr_valid && run_en;
        if (accept) begin
          state_nxt = EXEC;
          cnt_nxt   = i[8] ? rep_cnt : '0;
        end
      end
      EXEC: begin
        busy        = 1'b1;
        instr_ready = last;
        select_a_hi = NREGS'(1) << ir_a;
        select_b_hi = NREGS'(1) << ir_b;
        reg_wr      = d[2] | d[1];
        q_wr        = (d == 3'b000) || (d == 3'b100) || (d == 3'b110);
        y_sel_a     = (d == 3'b010);
        shift_left  = d[2] & d[1];
        shift_right = d[2] & ~d[1];
        if (!last) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          accept = instr_valid;
          if (accept) begin
            cnt_nxt = i[8] ? rep_cnt : '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
